prog_loader: RTL and testbench

//  Upstream feeder for the instruction ROM programming port. Consumes a byte

---
 rtl/prog_loader_pkg.sv | 46 ++++
 rtl/prog_loader.sv | 275 +++++++++++++++++++++++++++
 tb/tb_prog_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// prog_loader_pkg
//
// Shared attributes for the instruction ROM and the loader that feeds its
// programming port: instruction word geometry, ROM depth, the frame start
// marker and the loader state encoding.
//
// Contents:
//    IR_WIDTH        width of one instruction word
//    ROM_DEPTH       number of words the ROM holds
//    BPW             bytes per instruction word on the byte stream
//    ADDR_WIDTH      ROM address width
//    PROG_SYNC_BYTE  default frame start marker
//    ir_word_t       one instruction word
//    rom_addr_t      one ROM address
//    prog_ld_state_t loader FSM states
//
// Optional feature macro used by the loader: PROG_LOADER_CKSUM_EN
// ---------------------------------------------------------------------------
package prog_loader_pkg;

   localparam int IR_WIDTH   = 16;
   localparam int ROM_DEPTH  = 64;
   localparam int BPW        = (IR_WIDTH + 7) / 8;
   localparam int ADDR_WIDTH = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

   localparam logic [7:0] PROG_SYNC_BYTE = 8'hA5;

   typedef logic [IR_WIDTH-1:0]   ir_word_t;
   typedef logic [ADDR_WIDTH-1:0] rom_addr_t;

   // S_HDR0/S_HDR1 collect the little-endian word count, S_ASM gathers the
   // bytes of one word, S_LO/S_AVAIL/S_REL run the ROM handshake for it.
   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_HDR0  = 4'd1,
      S_HDR1  = 4'd2,
      S_ASM   = 4'd3,
      S_LO    = 4'd4,
      S_AVAIL = 4'd5,
      S_REL   = 4'd6,
      S_TAIL  = 4'd7,
      S_DONE  = 4'd8
   } prog_ld_state_t;

endpackage

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Sits between a UART receiver and the instruction ROM programming port.
// It accepts a framed byte stream
//    SYNC_BYTE, COUNT[7:0], COUNT[15:8], COUNT words of BPW bytes each
//    (little-endian), optionally followed by one checksum byte,
// assembles the bytes into instruction words and hands them to the ROM one
// at a time using the prog / p_avail / p_d_in / p_ready / p_lo_ack handshake.
//
// Ports:
//    clk       in   system clock
//    rst_n     in   asynchronous active-low reset
//    rx_data   in   incoming byte
//    rx_valid  in   rx_data valid
//    rx_ready  out  byte accepted when rx_valid & rx_ready
//    prog      out  programming session active (ROM prog)
//    p_avail   out  p_d_in valid towards the ROM
//    p_d_in    out  instruction word being written
//    p_ready   in   ROM committed the current word
//    p_lo_ack  in   ROM idle, ready for the next word
//    busy      out  frame in progress
//    done      out  one-cycle pulse: frame completed, prog released
//    err       out  sticky error, cleared by the next SYNC_BYTE
//
// Optional feature: define PROG_LOADER_CKSUM_EN to require a trailing byte
// equal to the XOR of every byte after SYNC_BYTE. A mismatch raises err but
// the frame still completes normally (words already written stay in the ROM).
// Without the macro there is no checksum byte and err only flags an
// oversized word count.
// ---------------------------------------------------------------------------
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = PROG_SYNC_BYTE,
   parameter int         MAX_WORDS = ROM_DEPTH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   output logic                rx_ready,
   output logic                prog,
   output logic                p_avail,
   output logic [IR_WIDTH-1:0] p_d_in,
   input  logic                p_ready,
   input  logic                p_lo_ack,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int               IDX_W     = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BPW - 1);
   localparam logic [15:0]      MAX_COUNT = MAX_WORDS[15:0];

   prog_ld_state_t   state;
   prog_ld_state_t   state_nxt;

   logic             live;
   logic             accept;
   logic [15:0]      count;
   logic [15:0]      hdr_count;
   logic [15:0]      word_cnt;
   logic [15:0]      word_cnt_inc;
   logic [IDX_W-1:0] byte_idx;
   logic             last_byte;
   logic [BPW*8-1:0] asm_buf;

`ifdef PROG_LOADER_CKSUM_EN
   logic [7:0]       cksum;
`endif

   assign accept       = rx_valid & rx_ready;
   assign hdr_count    = {rx_data, count[7:0]};
   assign word_cnt_inc = word_cnt + 16'd1;
   assign last_byte    = (byte_idx == LAST_IDX);
   assign p_d_in       = asm_buf[IR_WIDTH-1:0];

   // State register. Reset drops straight to S_IDLE, which in turn pulls
   // prog, p_avail and busy low in the same cycle as the reset assertion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. Words are committed strictly in the order
   // S_ASM -> S_LO -> S_AVAIL -> S_REL -> S_ASM so that p_avail can only
   // rise after the ROM has reported idle via p_lo_ack.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (accept && (rx_data == SYNC_BYTE)) begin
               state_nxt = S_HDR0;
            end
         end
         S_HDR0: begin
            if (accept) begin
               state_nxt = S_HDR1;
            end
         end
         S_HDR1: begin
            if (accept) begin
               if (hdr_count == 16'd0) begin
                  state_nxt = S_DONE;
               end else if (hdr_count > MAX_COUNT) begin
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_ASM;
               end
            end
         end
         S_ASM: begin
            if (accept && last_byte) begin
               state_nxt = S_LO;
            end
         end
         S_LO: begin
            if (p_lo_ack) begin
               state_nxt = S_AVAIL;
            end
         end
         S_AVAIL: begin
            if (p_ready) begin
               state_nxt = (word_cnt_inc == count) ? S_TAIL : S_REL;
            end
         end
         S_REL: begin
            if (p_lo_ack) begin
               state_nxt = S_ASM;
            end
         end
         S_TAIL: begin
`ifdef PROG_LOADER_CKSUM_EN
            if (accept) begin
               state_nxt = S_DONE;
            end
`else
            state_nxt = S_DONE;
`endif
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Output decode. Everything except rx_ready is a pure function of the
   // state register, so the ROM-facing signals are glitch-free and prog is
   // high continuously from the first word until S_DONE. rx_ready is also
   // gated by live so that every output reads 0 while reset is held.
   always_comb begin
      rx_ready = 1'b0;
      prog     = 1'b0;
      p_avail  = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      unique case (state)
         S_IDLE: begin
            rx_ready = live;
            busy     = 1'b0;
         end
         S_HDR0, S_HDR1: begin
            rx_ready = live;
         end
         S_ASM: begin
            rx_ready = live;
            prog     = 1'b1;
         end
         S_LO, S_REL: begin
            prog = 1'b1;
         end
         S_AVAIL: begin
            prog    = 1'b1;
            p_avail = 1'b1;
         end
         S_TAIL: begin
            prog = 1'b1;
`ifdef PROG_LOADER_CKSUM_EN
            rx_ready = live;
`endif
         end
         S_DONE: begin
            busy = 1'b0;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Datapath: header count, word assembler, committed-word counter, the
   // sticky error flag and (optionally) the running checksum. The assembler
   // only writes in S_ASM, which guarantees p_d_in never moves while
   // p_avail is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live     <= 1'b0;
         count    <= 16'd0;
         word_cnt <= 16'd0;
         byte_idx <= '0;
         asm_buf  <= '0;
         err      <= 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
         cksum    <= 8'd0;
`endif
      end else begin
         live <= 1'b1;
         unique case (state)
            S_IDLE: begin
               if (accept && (rx_data == SYNC_BYTE)) begin
                  err      <= 1'b0;
                  count    <= 16'd0;
                  word_cnt <= 16'd0;
                  byte_idx <= '0;
`ifdef PROG_LOADER_CKSUM_EN
                  cksum    <= 8'd0;
`endif
               end
            end
            S_HDR0: begin
               if (accept) begin
                  count[7:0] <= rx_data;
`ifdef PROG_LOADER_CKSUM_EN
                  cksum      <= cksum ^ rx_data;
`endif
               end
            end
            S_HDR1: begin
               if (accept) begin
                  count[15:8] <= rx_data;
`ifdef PROG_LOADER_CKSUM_EN
                  cksum       <= cksum ^ rx_data;
`endif
                  if (hdr_count > MAX_COUNT) begin
                     err <= 1'b1;
                  end
               end
            end
            S_ASM: begin
               if (accept) begin
                  asm_buf[8*byte_idx +: 8] <= rx_data;
                  byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
`ifdef PROG_LOADER_CKSUM_EN
                  cksum    <= cksum ^ rx_data;
`endif
               end
            end
            S_AVAIL: begin
               if (p_ready) begin
                  word_cnt <= word_cnt_inc;
               end
            end
            S_TAIL: begin
`ifdef PROG_LOADER_CKSUM_EN
               if (accept && (rx_data != cksum)) begin
                  err <= 1'b1;
               end
`endif
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//
// Self-checking bench for prog_loader. A byte driver sends frames, a ROM model
// answers the programming handshake with random delays, and a monitor pops
// expected words and frame results from scoreboard queues as the DUT
// presents them. Honours PROG_LOADER_CKSUM_EN in the same way as the DUT.
// ---------------------------------------------------------------------------
module tb_prog_loader;
   import prog_loader_pkg::*;

   logic                clk;
   logic                rst_n;
   logic [7:0]          rx_data;
   logic                rx_valid;
   logic                rx_ready;
   logic                prog;
   logic                p_avail;
   logic [IR_WIDTH-1:0] p_d_in;
   logic                p_ready;
   logic                p_lo_ack;
   logic                busy;
   logic                done;
   logic                err;

   int vectors;
   int miscompares;

   ir_word_t exp_words[$];
   logic     exp_done[$];
   ir_word_t frame[$];
   logic     prog_seen;
   logic     lo_seen;

   prog_loader dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .prog     (prog),
      .p_avail  (p_avail),
      .p_d_in   (p_d_in),
      .p_ready  (p_ready),
      .p_lo_ack (p_lo_ack),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: bumps the vector count and reports a mismatch.
   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one byte and hold it until the DUT takes it (bounded wait).
   task automatic send_byte(input logic [7:0] b);
      int  waited;
      bit  taken;
      waited   = 0;
      taken    = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!taken && waited < 3000) begin
         @(negedge clk);
         if (rx_ready) begin
            taken = 1;
         end else begin
            waited++;
         end
      end
      if (!taken) begin
         check_output("rx_ready timeout", {31'd0, rx_ready}, 32'd1);
         rx_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         rx_valid = 1'b0;
      end
   endtask

   // Send a full frame built from 'frame'; model expectations go to queues.
   task automatic apply_stimulus(input bit corrupt);
      int unsigned n;
      logic [7:0]  sum;
      logic [7:0]  b;
      n   = frame.size();
      sum = 8'd0;
`ifdef PROG_LOADER_CKSUM_EN
      exp_done.push_back(corrupt && (n != 0));
`else
      exp_done.push_back(1'b0);
`endif
      send_byte(PROG_SYNC_BYTE);
      b = n[7:0];
      sum ^= b;
      send_byte(b);
      b = n[15:8];
      sum ^= b;
      send_byte(b);
      for (int i = 0; i < int'(n); i++) begin
         exp_words.push_back(frame[i]);
         for (int k = 0; k < BPW; k++) begin
            b = 8'((32'(frame[i]) >> (8 * k)) & 32'hFF);
            sum ^= b;
            idle_cycles($urandom_range(0, 2));
            send_byte(b);
         end
      end
`ifdef PROG_LOADER_CKSUM_EN
      if (n != 0) begin
         send_byte(corrupt ? ~sum : sum);
      end
`else
      if (corrupt) begin
         sum = ~sum;
      end
`endif
   endtask

   task automatic wait_frame_done(input string name);
      int t;
      t = 0;
      while (exp_done.size() != 0 && t < 5000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check_output(name, exp_done.size(), 32'd0);
   endtask

   // ROM model: advertise idle after a random delay, commit each offered
   // word after a random delay, then go back to idle.
   initial begin : rom_model
      p_lo_ack = 1'b0;
      p_ready  = 1'b0;
      forever begin
         repeat ($urandom_range(0, 7)) @(posedge clk);
         #1;
         p_lo_ack = 1'b1;
         while (!p_avail) begin
            @(posedge clk);
            #1;
         end
         p_lo_ack = 1'b0;
         repeat ($urandom_range(0, 7)) @(posedge clk);
         #1;
         p_ready = 1'b1;
         @(posedge clk);
         #1;
         p_ready = 1'b0;
         while (p_avail) begin
            @(posedge clk);
            #1;
         end
      end
   end

   // Monitor: sampled on the falling edge, between DUT updates.
   initial begin : monitor
      logic prev_avail;
      logic prev_done;
      logic prev_prog;
      logic e;
      prev_avail = 1'b0;
      prev_done  = 1'b0;
      prev_prog  = 1'b0;
      lo_seen    = 1'b0;
      prog_seen  = 1'b0;
      forever begin
         @(negedge clk);
         if (prog) prog_seen = 1'b1;
         if (p_avail && !prev_avail) begin
            check_output("p_avail after p_lo_ack", {31'd0, lo_seen}, 32'd1);
            lo_seen = 1'b0;
         end
         if (p_avail) begin
            check_output("word pending", {31'd0, exp_words.size() != 0}, 32'd1);
            if (exp_words.size() != 0) begin
               check_output("p_d_in", 32'(p_d_in), 32'(exp_words[0]));
            end
            check_output("prog during word", {31'd0, prog}, 32'd1);
            if (p_ready && exp_words.size() != 0) begin
               void'(exp_words.pop_front());
            end
         end
         if (done) begin
            check_output("done expected", {31'd0, exp_done.size() != 0}, 32'd1);
            if (exp_done.size() != 0) begin
               e = exp_done.pop_front();
               check_output("err at done", {31'd0, err}, {31'd0, e});
            end
            check_output("prog at done", {31'd0, prog}, 32'd0);
         end
         if (prev_done) check_output("done one cycle", {31'd0, done}, 32'd0);
         if (prev_prog && !prog) check_output("prog held while busy", {31'd0, busy}, 32'd0);
         if (!p_avail && p_lo_ack) lo_seen = 1'b1;
         prev_avail = p_avail;
         prev_done  = done;
         prev_prog  = prog;
      end
   end

   initial begin : watchdog
      #600000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      rx_valid    = 1'b0;
      rx_data     = 8'h00;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_output("reset rx_ready", {31'd0, rx_ready}, 32'd0);
      check_output("reset prog", {31'd0, prog}, 32'd0);
      check_output("reset p_avail", {31'd0, p_avail}, 32'd0);
      check_output("reset busy", {31'd0, busy}, 32'd0);
      check_output("reset done", {31'd0, done}, 32'd0);
      check_output("reset err", {31'd0, err}, 32'd0);
      check_output("reset p_d_in", 32'(p_d_in), 32'd0);
      rst_n = 1'b1;
      idle_cycles(1);
      check_output("idle rx_ready", {31'd0, rx_ready}, 32'd1);

      // Noise before a frame is dropped
      send_byte(8'h3C);
      check_output("noise busy", {31'd0, busy}, 32'd0);

      // Directed two-word frame
      frame = '{16'h1234, 16'hABCD};
      apply_stimulus(1'b0);
      wait_frame_done("two-word frame");

      // Zero-count frame: done one cycle after the count byte, no prog
      prog_seen = 1'b0;
      exp_done.push_back(1'b0);
      send_byte(PROG_SYNC_BYTE);
      check_output("sync busy", {31'd0, busy}, 32'd1);
      send_byte(8'h00);
      send_byte(8'h00);
      check_output("zero count done", {31'd0, done}, 32'd1);
      idle_cycles(1);
      check_output("zero count done cleared", {31'd0, done}, 32'd0);
      check_output("zero count prog", {31'd0, prog_seen}, 32'd0);
      wait_frame_done("zero-count frame");

      // Oversized count: err, no prog, back to accepting bytes
      prog_seen = 1'b0;
      send_byte(PROG_SYNC_BYTE);
      send_byte(8'((ROM_DEPTH + 1) & 255));
      send_byte(8'((ROM_DEPTH + 1) >> 8));
      check_output("overflow err", {31'd0, err}, 32'd1);
      check_output("overflow busy", {31'd0, busy}, 32'd0);
      check_output("overflow rx_ready", {31'd0, rx_ready}, 32'd1);
      idle_cycles(4);
      check_output("overflow err sticky", {31'd0, err}, 32'd1);
      check_output("overflow prog", {31'd0, prog_seen}, 32'd0);
      exp_done.push_back(1'b0);
      send_byte(PROG_SYNC_BYTE);
      check_output("sync clears err", {31'd0, err}, 32'd0);
      send_byte(8'h00);
      send_byte(8'h00);
      wait_frame_done("frame after overflow");

      // Largest accepted count
      frame = {};
      for (int i = 0; i < ROM_DEPTH; i++) frame.push_back(ir_word_t'($urandom));
      apply_stimulus(1'b0);
      wait_frame_done("max-count frame");

      // Randomized frames
      for (int f = 0; f < 10; f++) begin
         frame = {};
         for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
            frame.push_back(ir_word_t'($urandom));
         end
         apply_stimulus($urandom_range(0, 3) == 0);
         wait_frame_done("random frame");
      end

`ifdef PROG_LOADER_CKSUM_EN
      frame = '{16'h0F0F, 16'h5AA5, 16'h1357};
      apply_stimulus(1'b0);
      wait_frame_done("checksum good frame");
      frame = '{16'hCAFE, 16'h0001};
      apply_stimulus(1'b1);
      wait_frame_done("checksum bad frame");
`endif

      // Reset during word 3 of 5
      send_byte(PROG_SYNC_BYTE);
      send_byte(8'd5);
      send_byte(8'd0);
      for (int i = 0; i < 2; i++) begin
         frame = '{ir_word_t'($urandom)};
         exp_words.push_back(frame[0]);
         for (int k = 0; k < BPW; k++) begin
            send_byte(8'((32'(frame[0]) >> (8 * k)) & 32'hFF));
         end
      end
      send_byte(8'h77);
      check_output("mid-session prog", {31'd0, prog}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_output("reset drops prog", {31'd0, prog}, 32'd0);
      check_output("reset drops p_avail", {31'd0, p_avail}, 32'd0);
      check_output("reset drops busy", {31'd0, busy}, 32'd0);
      check_output("reset no done", {31'd0, done}, 32'd0);
      idle_cycles(2);
      rst_n = 1'b1;
      idle_cycles(2);

      // New frame after reset
      frame = '{16'h2468, 16'h9BDF, 16'h0000};
      apply_stimulus(1'b0);
      wait_frame_done("frame after reset");

      idle_cycles(10);
      check_output("words left", exp_words.size(), 32'd0);
      check_output("frames left", exp_done.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
